// File: rtl/mips_defs.sv
// Shared widths and sizing defaults for the mips core memory path.
package mips_defs;

  localparam int unsigned MIPS_AW    = 32;
  localparam int unsigned MIPS_DW    = 32;
  localparam int unsigned WBUF_DEPTH = 4;
  // Width of a word address: the byte address with the two offset bits dropped.
  localparam int unsigned MIPS_WAW   = MIPS_AW - 2;

endpackage

// File: rtl/wbuf_fwd_match.sv
// Store-to-load forwarding lookup: compares a load word address against
// every valid buffer entry and returns the data of the youngest match.
module wbuf_fwd_match #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WAW   = 30,
  parameter int unsigned DW    = 32
) (
  input  logic [DEPTH-1:0]         valid,
  input  logic [WAW-1:0]           addr [DEPTH],
  input  logic [DW-1:0]            data [DEPTH],
  input  logic [$clog2(DEPTH)-1:0] head,
  input  logic [WAW-1:0]           load_addr,
  output logic                     hit,
  output logic [DW-1:0]            hit_data
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk entries oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned age = 0; age < DEPTH; age++) begin
      idx = head + PW'(age);
      if (valid[idx] && (addr[idx] == load_addr)) begin
        hit      = 1'b1;
        hit_data = data[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_write_buffer.sv
// Posted-store buffer between the MEM stage and data memory: stores queue in a
// circular FIFO, drain one per idle cycle, and loads forward from pending stores.
module dmem_write_buffer
  import mips_defs::*;
#(
  parameter int unsigned DEPTH = WBUF_DEPTH,
  parameter int unsigned AW    = MIPS_AW,
  parameter int unsigned DW    = MIPS_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWriteM,
  input  logic          MemReadM,
  input  logic [AW-1:0] ALUOutM,
  input  logic [DW-1:0] WriteDataM,
  output logic [DW-1:0] ReadDataM,
  output logic          StallM,
  output logic          BufEmpty,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned WAW = AW - 2;

  logic [WAW-1:0]   ent_addr [DEPTH];
  logic [DW-1:0]    ent_data [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;

  logic          full;
  logic          push;
  logic          drain;
  logic          hit;
  logic [DW-1:0] hit_data;

  assign full     = (count == CW'(DEPTH));
  assign push     = MemWriteM & ~full;
  assign drain    = (count != '0) & ~MemReadM;
  assign StallM   = MemWriteM & full;
  assign BufEmpty = (count == '0);

  // A load owns the memory port; otherwise the head entry is presented.
  // The write strobe is held off during reset so discarded stores never land.
  assign mem_we    = drain & ~reset;
  assign mem_addr  = MemReadM ? ALUOutM : {ent_addr[head], 2'b00};
  assign mem_wdata = ent_data[head];
  assign ReadDataM = !MemReadM ? '0 : (hit ? hit_data : mem_rdata);

  wbuf_fwd_match #(
    .DEPTH (DEPTH),
    .WAW   (WAW),
    .DW    (DW)
  ) u_fwd (
    .valid     (valid),
    .addr      (ent_addr),
    .data      (ent_data),
    .head      (head),
    .load_addr (ALUOutM[AW-1:2]),
    .hit       (hit),
    .hit_data  (hit_data)
  );

  // Storage, pointers and occupancy; push and drain never target the same slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      ent_addr <= '{default: '0};
      ent_data <= '{default: '0};
    end else begin
      if (push) begin
        ent_addr[tail] <= ALUOutM[AW-1:2];
        ent_data[tail] <= WriteDataM;
        valid[tail]    <= 1'b1;
        tail           <= tail + PW'(1);
      end
      if (drain) begin
        valid[head] <= 1'b0;
        head        <= head + PW'(1);
      end
      case ({push, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
